// File: rtl/rv32imf_writeback_arbiter.sv
// Register-file writeback arbiter for the RV32IMF core.
// Port B carries LSU load data. Port A carries ALU results first, then either a
// MUL/DIV result or the head of a small FPU result FIFO, round-robin between those two.
// Any write that targets the same address as a concurrent LSU write yields to the load.
module rv32imf_writeback_arbiter #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int FPU_FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_we_i,
    input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
    input  logic [DATA_WIDTH-1:0] alu_wdata_i,
    input  logic                  lsu_we_i,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    input  logic                  mul_valid_i,
    output logic                  mul_ready_o,
    input  logic [ADDR_WIDTH-1:0] mul_waddr_i,
    input  logic [DATA_WIDTH-1:0] mul_wdata_i,
    input  logic                  fpu_valid_i,
    output logic                  fpu_ready_o,
    input  logic [ADDR_WIDTH-1:0] fpu_waddr_i,
    input  logic [DATA_WIDTH-1:0] fpu_wdata_i,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    output logic                  we_b_o,
    output logic                  alu_collision_o,
    output logic                  busy_o
);

    localparam int PTR_W = $clog2(FPU_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FPU result FIFO storage and bookkeeping
    logic [ADDR_WIDTH-1:0] fifo_addr_q [FPU_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FPU_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // 1 = FPU was granted last, so MUL wins the next tie
    logic                  rr_fpu_last_q, rr_fpu_last_d;

    // Registered write ports
    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d;
    logic                  we_a_q, we_a_d;
    logic                  collision_q, collision_d;
    logic [ADDR_WIDTH-1:0] waddr_b_q;
    logic [DATA_WIDTH-1:0] wdata_b_q;
    logic                  we_b_q;

    logic                  head_valid, fifo_full;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  collide_alu, collide_mul, collide_head;
    logic                  mul_req, fpu_req, grant_mul, grant_fpu;
    logic                  fifo_push, fifo_pop;

    assign head_valid = (count_q != '0);
    assign fifo_full  = (count_q == CNT_W'(FPU_FIFO_DEPTH));
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];

    // A load to a nonzero register always wins over any other write to that register
    assign collide_alu  = lsu_we_i && (alu_waddr_i == lsu_waddr_i) && (alu_waddr_i != '0);
    assign collide_mul  = lsu_we_i && (mul_waddr_i == lsu_waddr_i) && (mul_waddr_i != '0);
    assign collide_head = lsu_we_i && (head_addr == lsu_waddr_i) && (head_addr != '0);

    // Round-robin between MUL and FIFO head; a colliding source steps aside this cycle
    always_comb begin
        mul_req   = mul_valid_i & ~collide_mul;
        fpu_req   = head_valid & ~collide_head;
        grant_mul = mul_req & (~fpu_req | rr_fpu_last_q);
        grant_fpu = fpu_req & (~mul_req | ~rr_fpu_last_q);
    end

    assign mul_ready_o = mul_valid_i & ~alu_we_i & grant_mul & ~collide_mul;
    assign fifo_pop    = head_valid & ~alu_we_i & grant_fpu & ~collide_head;
    assign fifo_push   = fpu_valid_i & ~fifo_full;
    assign fpu_ready_o = ~fifo_full;
    assign busy_o      = head_valid | mul_valid_i;

    // Next-state for port A, the round-robin pointer and FIFO pointers
    always_comb begin
        waddr_a_d     = waddr_a_q;
        wdata_a_d     = wdata_a_q;
        we_a_d        = 1'b0;
        collision_d   = 1'b0;
        rr_fpu_last_d = rr_fpu_last_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (alu_we_i) begin
            waddr_a_d   = alu_waddr_i;
            wdata_a_d   = alu_wdata_i;
            we_a_d      = ~collide_alu && (alu_waddr_i != '0);
            collision_d = collide_alu;
        end else if (mul_ready_o) begin
            waddr_a_d     = mul_waddr_i;
            wdata_a_d     = mul_wdata_i;
            we_a_d        = (mul_waddr_i != '0);
            rr_fpu_last_d = 1'b0;
        end else if (fifo_pop) begin
            waddr_a_d     = head_addr;
            wdata_a_d     = head_data;
            we_a_d        = (head_addr != '0);
            rr_fpu_last_d = 1'b1;
        end

        if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (fifo_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset flushes the FIFO and clears both write ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr_a_q     <= '0;
            wdata_a_q     <= '0;
            we_a_q        <= 1'b0;
            collision_q   <= 1'b0;
            waddr_b_q     <= '0;
            wdata_b_q     <= '0;
            we_b_q        <= 1'b0;
            rr_fpu_last_q <= 1'b1;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            waddr_a_q     <= waddr_a_d;
            wdata_a_q     <= wdata_a_d;
            we_a_q        <= we_a_d;
            collision_q   <= collision_d;
            waddr_b_q     <= lsu_waddr_i;
            wdata_b_q     <= lsu_wdata_i;
            we_b_q        <= lsu_we_i && (lsu_waddr_i != '0);
            rr_fpu_last_q <= rr_fpu_last_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO payload storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_addr_q[wr_ptr_q] <= fpu_waddr_i;
            fifo_data_q[wr_ptr_q] <= fpu_wdata_i;
        end
    end

    assign waddr_a_o       = waddr_a_q;
    assign wdata_a_o       = wdata_a_q;
    assign we_a_o          = we_a_q;
    assign alu_collision_o = collision_q;
    assign waddr_b_o       = waddr_b_q;
    assign wdata_b_o       = wdata_b_q;
    assign we_b_o          = we_b_q;

endmodule

// File: tb/tb_rv32imf_writeback_arbiter.sv
// Self-checking bench for rv32imf_writeback_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based behavioural model.
module tb_rv32imf_writeback_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_we_i = 0, lsu_we_i = 0, mul_valid_i = 0, fpu_valid_i = 0;
    logic [5:0]  alu_waddr_i = 0, lsu_waddr_i = 0, mul_waddr_i = 0, fpu_waddr_i = 0;
    logic [31:0] alu_wdata_i = 0, lsu_wdata_i = 0, mul_wdata_i = 0, fpu_wdata_i = 0;
    logic        mul_ready_o, fpu_ready_o, we_a_o, we_b_o, alu_collision_o, busy_o;
    logic [5:0]  waddr_a_o, waddr_b_o;
    logic [31:0] wdata_a_o, wdata_b_o;

    rv32imf_writeback_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_we_i(alu_we_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
        .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .mul_valid_i(mul_valid_i), .mul_ready_o(mul_ready_o),
        .mul_waddr_i(mul_waddr_i), .mul_wdata_i(mul_wdata_i),
        .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
        .fpu_waddr_i(fpu_waddr_i), .fpu_wdata_i(fpu_wdata_i),
        .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
        .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .we_b_o(we_b_o),
        .alu_collision_o(alu_collision_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model: FIFO as a queue, plus who was granted last between MUL and FPU
    typedef struct packed { logic [5:0] a; logic [31:0] d; } ent_t;
    ent_t        fq[$];
    bit          m_fpu_last = 1'b1;
    bit          m_mul_acc, m_fpu_acc;
    logic        obs_mul_ready;
    logic        e_we_a, e_col, e_we_b;
    logic [5:0]  e_waddr_a, e_waddr_b;
    logic [31:0] e_wdata_a, e_wdata_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_coll(input logic [5:0] a);
        return lsu_we_i && (a == lsu_waddr_i) && (a != 6'd0);
    endfunction

    task automatic set_idle();
        alu_we_i = 0; lsu_we_i = 0; mul_valid_i = 0; fpu_valid_i = 0;
    endtask

    function automatic logic [5:0] raddr();
        case ($urandom % 6)
            0: return 6'd0;
            1: return 6'd7;
            2: return 6'd32;
            3: return 6'd33;
            default: return 6'($urandom_range(1, 63));
        endcase
    endfunction

    // One clock cycle: inputs are already applied; check handshakes, then the registered ports
    task automatic step(input string tag);
        bit   mul_can, fifo_can;
        int   win;
        ent_t h;
        #1;
        mul_can  = mul_valid_i && !alu_we_i && !m_coll(mul_waddr_i);
        fifo_can = (fq.size() > 0) && !alu_we_i && !m_coll(fq[0].a);
        if (mul_can && fifo_can) win = m_fpu_last ? 1 : 2;
        else if (mul_can)        win = 1;
        else if (fifo_can)       win = 2;
        else                     win = 0;
        obs_mul_ready = mul_ready_o;
        chk({tag, ".fpu_ready"}, fpu_ready_o, fq.size() < DEPTH);
        chk({tag, ".busy"}, busy_o, (fq.size() != 0) || mul_valid_i);
        chk({tag, ".mul_ready"}, mul_ready_o, win == 1);

        e_we_b = lsu_we_i && (lsu_waddr_i != 0);
        e_waddr_b = lsu_waddr_i;
        e_wdata_b = lsu_wdata_i;
        e_col = 0;
        e_we_a = 0;
        m_fpu_acc = fpu_valid_i && (fq.size() < DEPTH);
        m_mul_acc = (win == 1);
        if (alu_we_i) begin
            e_col = m_coll(alu_waddr_i);
            e_we_a = !e_col && (alu_waddr_i != 0);
            e_waddr_a = alu_waddr_i;
            e_wdata_a = alu_wdata_i;
        end else if (win == 1) begin
            e_we_a = (mul_waddr_i != 0);
            e_waddr_a = mul_waddr_i;
            e_wdata_a = mul_wdata_i;
            m_fpu_last = 0;
        end else if (win == 2) begin
            h = fq.pop_front();
            e_we_a = (h.a != 0);
            e_waddr_a = h.a;
            e_wdata_a = h.d;
            m_fpu_last = 1;
        end
        if (m_fpu_acc) fq.push_back({fpu_waddr_i, fpu_wdata_i});

        @(posedge clk);
        #1;
        chk({tag, ".we_a"}, we_a_o, e_we_a);
        chk({tag, ".collision"}, alu_collision_o, e_col);
        chk({tag, ".we_b"}, we_b_o, e_we_b);
        chk({tag, ".waddr_b"}, waddr_b_o, e_waddr_b);
        chk({tag, ".wdata_b"}, wdata_b_o, e_wdata_b);
        if (e_we_a) begin
            chk({tag, ".waddr_a"}, waddr_a_o, e_waddr_a);
            chk({tag, ".wdata_a"}, wdata_a_o, e_wdata_a);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        m_fpu_last = 1;
    endtask

    initial begin
        bit mul_pend = 0;
        bit fpu_pend = 0;

        // Reset with random activity on every input except MUL valid
        rst = 1;
        alu_we_i = 1'($urandom); alu_waddr_i = raddr(); alu_wdata_i = $urandom;
        lsu_we_i = 1'($urandom); lsu_waddr_i = raddr(); lsu_wdata_i = $urandom;
        fpu_valid_i = 1'($urandom); fpu_waddr_i = raddr(); fpu_wdata_i = $urandom;
        mul_valid_i = 0; mul_waddr_i = raddr(); mul_wdata_i = $urandom;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.we_a", we_a_o, 0);
        chk("rst.we_b", we_b_o, 0);
        chk("rst.collision", alu_collision_o, 0);
        chk("rst.waddr_a", waddr_a_o, 0);
        chk("rst.fpu_ready", fpu_ready_o, 1);
        chk("rst.busy", busy_o, 0);
        rst = 0;
        set_idle();
        model_reset();

        // ALU and LSU to different registers in the same cycle
        alu_we_i = 1; alu_waddr_i = 6'd5; alu_wdata_i = 32'hDEADBEEF;
        lsu_we_i = 1; lsu_waddr_i = 6'h23; lsu_wdata_i = 32'h1234;
        step("dual");
        chk("dual.waddr_a5", waddr_a_o, 6'd5);
        chk("dual.we_a1", we_a_o, 1);
        chk("dual.waddr_b23", waddr_b_o, 6'h23);
        chk("dual.wdata_b", wdata_b_o, 32'h1234);
        set_idle();

        // FIFO fill while ALU owns port A, then in-order drain
        alu_we_i = 1; alu_waddr_i = 6'd1; alu_wdata_i = 32'h11;
        fpu_valid_i = 1; fpu_waddr_i = 6'h21; fpu_wdata_i = 32'hF1;
        step("fill1");
        fpu_waddr_i = 6'h22; fpu_wdata_i = 32'hF2;
        step("fill2");
        chk("fill.full", fpu_ready_o, 0);
        fpu_waddr_i = 6'h23; fpu_wdata_i = 32'hF3;
        step("fill3");
        step("fill4");
        alu_we_i = 0;
        step("drain1");
        chk("drain1.data", wdata_a_o, 32'hF1);
        step("drain2");
        chk("drain2.data", wdata_a_o, 32'hF2);
        fpu_valid_i = 0;
        step("drain3");
        chk("drain3.data", wdata_a_o, 32'hF3);

        // MUL and FIFO both pending: strict alternation starting with MUL
        alu_we_i = 1; alu_waddr_i = 6'd3;
        fpu_valid_i = 1; fpu_waddr_i = 6'h2A; fpu_wdata_i = 32'hA0;
        step("pre1");
        fpu_wdata_i = 32'hA1;
        step("pre2");
        fpu_valid_i = 0; alu_we_i = 0;
        mul_valid_i = 1; mul_waddr_i = 6'd10; mul_wdata_i = 32'hB0;
        step("rr1");
        chk("rr1.data", wdata_a_o, 32'hB0);
        mul_wdata_i = 32'hB1;
        step("rr2");
        chk("rr2.data", wdata_a_o, 32'hA0);
        step("rr3");
        chk("rr3.data", wdata_a_o, 32'hB1);
        mul_wdata_i = 32'hB2;
        step("rr4");
        chk("rr4.data", wdata_a_o, 32'hA1);
        step("rr5");
        chk("rr5.data", wdata_a_o, 32'hB2);
        set_idle();

        // Same-address collisions against a load
        alu_we_i = 1; alu_waddr_i = 6'd7; alu_wdata_i = 32'hAAAA;
        lsu_we_i = 1; lsu_waddr_i = 6'd7; lsu_wdata_i = 32'h5555;
        step("acol");
        chk("acol.we_a0", we_a_o, 0);
        chk("acol.flag", alu_collision_o, 1);
        chk("acol.waddr_b7", waddr_b_o, 6'd7);
        alu_we_i = 0;
        mul_valid_i = 1; mul_waddr_i = 6'd7; mul_wdata_i = 32'h77;
        step("mcol");
        chk("mcol.ready0", obs_mul_ready, 0);
        lsu_we_i = 0;
        step("mretry");
        chk("mretry.ready1", obs_mul_ready, 1);
        chk("mretry.data", wdata_a_o, 32'h77);
        set_idle();

        // x0 is never written; FP register 32 is
        alu_we_i = 1; alu_waddr_i = 6'd0; lsu_we_i = 1; lsu_waddr_i = 6'd0;
        step("x0");
        chk("x0.we_a", we_a_o, 0);
        chk("x0.we_b", we_b_o, 0);
        set_idle();
        mul_valid_i = 1; mul_waddr_i = 6'd0; mul_wdata_i = 32'h99;
        step("x0mul");
        chk("x0mul.ready", obs_mul_ready, 1);
        chk("x0mul.we_a", we_a_o, 0);
        set_idle();
        alu_we_i = 1; alu_waddr_i = 6'd32; alu_wdata_i = 32'hC0FFEE;
        step("f0");
        chk("f0.we_a", we_a_o, 1);
        chk("f0.waddr", waddr_a_o, 6'd32);
        set_idle();

        // Asynchronous reset in the middle of buffered FPU results
        alu_we_i = 1; alu_waddr_i = 6'd4;
        lsu_we_i = 1; lsu_waddr_i = 6'd9;
        fpu_valid_i = 1; fpu_waddr_i = 6'h30; fpu_wdata_i = 32'hE0;
        step("mid1");
        step("mid2");
        set_idle();
        #2 rst = 1;
        #1;
        chk("midrst.we_a", we_a_o, 0);
        chk("midrst.we_b", we_b_o, 0);
        chk("midrst.fpu_ready", fpu_ready_o, 1);
        chk("midrst.busy", busy_o, 0);
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        step("postrst");

        // Randomized traffic with held valid/ready producers
        for (int i = 0; i < 500; i++) begin
            alu_we_i = ($urandom % 10) < 3;
            alu_waddr_i = raddr(); alu_wdata_i = $urandom;
            lsu_we_i = ($urandom % 2) == 0;
            lsu_waddr_i = raddr(); lsu_wdata_i = $urandom;
            if (!mul_pend && ($urandom % 3) == 0) begin
                mul_pend = 1; mul_valid_i = 1;
                mul_waddr_i = raddr(); mul_wdata_i = $urandom;
            end
            if (!fpu_pend && ($urandom % 2) == 0) begin
                fpu_pend = 1; fpu_valid_i = 1;
                fpu_waddr_i = raddr(); fpu_wdata_i = $urandom;
            end
            step("rand");
            if (m_mul_acc) begin mul_pend = 0; mul_valid_i = 0; end
            if (m_fpu_acc) begin fpu_pend = 0; fpu_valid_i = 0; end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
